// File: rtl/dmem_arbiter_ctrl_if.sv
// dmem_arbiter_ctrl_if: requester, response and memory-side signals of the dmem arbiter
//   reqN_*  : request channel per requester (valid/ready, addr, wdata, we)
//   rspN_*  : response channel per requester (valid/ready, rdata, err)
//   Mem_Addr/Write_Data/MemWrite/MemRead/Read_Data : single-port data memory
//   modport slave  : the arbiter; modport master : requesters plus memory
interface dmem_arbiter_ctrl_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
  logic              req0_valid, req0_ready, req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid, rsp0_ready, rsp0_err;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid, rsp1_ready, rsp1_err;
  logic [DATA_W-1:0] rsp1_rdata;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data, Read_Data;
  logic              MemWrite, MemRead;
  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_we, rsp0_ready,
    input  req1_valid, req1_addr, req1_wdata, req1_we, rsp1_ready, Read_Data,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output Mem_Addr, Write_Data, MemWrite, MemRead
  );
  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_we, rsp0_ready,
    output req1_valid, req1_addr, req1_wdata, req1_we, rsp1_ready, Read_Data,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  Mem_Addr, Write_Data, MemWrite, MemRead
  );
endinterface

// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: round-robin two-port arbiter/sequencer for the 64-bit data memory
//   clk, reset (sync, active-high); bus: dmem_arbiter_ctrl_if.slave (two req/rsp ports + memory)
//   Optional macro DMEM_ADDR_CHECK_EN: out-of-range addresses skip the memory and return err=1
module dmem_arbiter_ctrl #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic last_grant, owner, a_we, err, bad, win1, acc0, acc1, rsp_hs, mem_ok;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, rdata;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES - 8);
  // a doubleword access must fit entirely inside the memory
  assign bad = CHECK && (a_addr > LIMIT);
  always_comb begin
    // port 1 wins when alone, or on a tie when port 0 was granted last
    win1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    acc0 = (state == IDLE) & ~reset & bus.req0_valid & ~win1;
    acc1 = (state == IDLE) & ~reset & win1;
    rsp_hs = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);
    state_nxt = (state == IDLE) ? ((acc0 | acc1) ? ACCESS : IDLE) :
                (state == ACCESS) ? RESP : (rsp_hs ? IDLE : RESP);
    mem_ok = (state == ACCESS) & ~reset & ~bad;
    bus.req0_ready = acc0;
    bus.req1_ready = acc1;
    bus.rsp0_valid = (state == RESP) & ~owner;
    bus.rsp1_valid = (state == RESP) & owner;
    bus.rsp0_rdata = owner ? '0 : rdata;
    bus.rsp1_rdata = owner ? rdata : '0;
    bus.rsp0_err = ~owner & err;
    bus.rsp1_err = owner & err;
    bus.MemWrite = mem_ok & a_we;
    bus.MemRead = mem_ok & ~a_we;
    bus.Mem_Addr = (state == ACCESS) ? a_addr : '0;
    bus.Write_Data = (state == ACCESS) ? a_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      a_addr <= '0;
      a_wdata <= '0;
      a_we <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc0 | acc1) begin
        last_grant <= acc1;
        owner <= acc1;
        a_addr <= acc1 ? bus.req1_addr : bus.req0_addr;
        a_wdata <= acc1 ? bus.req1_wdata : bus.req0_wdata;
        a_we <= acc1 ? bus.req1_we : bus.req0_we;
      end
      if (state == ACCESS) begin
        rdata <= (a_we | bad) ? '0 : bus.Read_Data;
        err <= bad;
      end
    end
  end
endmodule
